// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Two-master round-robin arbiter and sequencer for a single-port synchronous
//   RAM (registered read data, one cycle read latency). Each master holds a
//   stable command with req high until it sees a one-cycle ack; read results
//   come back later with a one-cycle rvalid pulse and stay on mX_rdata until
//   that master's next read completes.
//
//   Optional feature (compile-time macro RAM_ARB_CLEAR_EN): after reset the
//   arbiter walks every RAM address writing zero before accepting requests.
//   Without the macro, reset leads straight to IDLE.
//
// Parameters
//   AW  RAM address width
//   DW  RAM data width
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   mX_req/we/addr/wdata       master X command (X = 0, 1)
//   mX_ack                     command issued to the RAM this cycle
//   mX_rvalid/mX_rdata         read completion pulse and held read data
//   ram_ena/wena/addr/din      registered RAM command
//   ram_dout                   RAM registered read data
//   busy                       arbiter not in IDLE

module ram_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  output logic          ram_ena,
  output logic          ram_wena,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,

  output logic          busy
);

`ifdef RAM_ARB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA, CLEAR} state_t;
  localparam state_t RST_STATE = CLEAR;
  // One past the last address: the clear walk is finished when the counter
  // reaches this value.
  localparam logic [AW:0] CLR_END = {1'b1, {AW{1'b0}}};
`else
  typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;
  localparam state_t RST_STATE = IDLE;
`endif

  state_t state_q, state_d;

  // last_q: 0 = m0 was granted last, 1 = m1. Resets to m1 so m0 wins the
  // first tie.
  logic          last_q, last_d;

  logic          ram_ena_q, ram_ena_d;
  logic          ram_wena_q, ram_wena_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;

  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          m0_rvalid_q, m0_rvalid_d;
  logic          m1_rvalid_q, m1_rvalid_d;

`ifdef RAM_ARB_CLEAR_EN
  logic [AW:0]   clr_cnt_q, clr_cnt_d;
  logic          clr_done;
`endif

  logic          req_any;
  logic          grant_m1;

  // Arbitration: a lone request wins; on a tie the master not granted last wins.
  always_comb begin
    req_any  = m0_req | m1_req;
    grant_m1 = m1_req & (~m0_req | ~last_q);
  end

`ifdef RAM_ARB_CLEAR_EN
  always_comb begin
    clr_done = (clr_cnt_q == CLR_END);
  end
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Writes complete on the RAM edge ending ACCESS; reads need one more
        // cycle for the registered RAM output.
        state_d = ram_wena_q ? IDLE : RDATA;
      end
      RDATA: begin
        state_d = IDLE;
      end
`ifdef RAM_ARB_CLEAR_EN
      CLEAR: begin
        if (clr_done) begin
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next values: RAM command, owner, read capture
  // ---------------------------------------------------------------------------
  always_comb begin
    last_d      = last_q;
    ram_ena_d   = ram_ena_q;
    ram_wena_d  = ram_wena_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
`ifdef RAM_ARB_CLEAR_EN
    clr_cnt_d   = clr_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_any) begin
          ram_ena_d  = 1'b1;
          ram_wena_d = grant_m1 ? m1_we    : m0_we;
          ram_addr_d = grant_m1 ? m1_addr  : m0_addr;
          ram_din_d  = grant_m1 ? m1_wdata : m0_wdata;
          last_d     = grant_m1;
        end else begin
          ram_ena_d  = 1'b0;
          ram_wena_d = 1'b0;
        end
      end
      ACCESS: begin
        // A read keeps the command (ena=1, wena=0, same address) into RDATA.
        if (ram_wena_q) begin
          ram_ena_d  = 1'b0;
          ram_wena_d = 1'b0;
        end
      end
      RDATA: begin
        ram_ena_d  = 1'b0;
        ram_wena_d = 1'b0;
        if (last_q) begin
          m1_rdata_d  = ram_dout;
          m1_rvalid_d = 1'b1;
        end else begin
          m0_rdata_d  = ram_dout;
          m0_rvalid_d = 1'b1;
        end
      end
`ifdef RAM_ARB_CLEAR_EN
      CLEAR: begin
        // The command register runs one cycle behind the counter, so the
        // extra cycle at CLR_END lets the final write commit while still busy.
        if (!clr_done) begin
          ram_ena_d  = 1'b1;
          ram_wena_d = 1'b1;
          ram_addr_d = clr_cnt_q[AW-1:0];
          ram_din_d  = '0;
          clr_cnt_d  = clr_cnt_q + (AW+1)'(1);
        end else begin
          ram_ena_d  = 1'b0;
          ram_wena_d = 1'b0;
        end
      end
`endif
      default: begin
        ram_ena_d  = 1'b0;
        ram_wena_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= 1'b1;
      ram_ena_q   <= 1'b0;
      ram_wena_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
    end else begin
      last_q      <= last_d;
      ram_ena_q   <= ram_ena_d;
      ram_wena_q  <= ram_wena_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
    end
  end

`ifdef RAM_ARB_CLEAR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_cnt_q <= '0;
    end else begin
      clr_cnt_q <= clr_cnt_d;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    m0_ack    = (state_q == ACCESS) & ~last_q;
    m1_ack    = (state_q == ACCESS) &  last_q;
    m0_rvalid = m0_rvalid_q;
    m1_rvalid = m1_rvalid_q;
    m0_rdata  = m0_rdata_q;
    m1_rdata  = m1_rdata_q;
    ram_ena   = ram_ena_q;
    ram_wena  = ram_wena_q;
    ram_addr  = ram_addr_q;
    ram_din   = ram_din_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: self-checking bench for ram_arbiter with a behavioural RAM,
// a table of single/dual transactions, hand-written corner sequences and a
// randomized phase checked against a cycle-count reference model.
// Set RAM_ARB_CLEAR_EN to exercise the clear-after-reset variant.

module tb_ram_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef RAM_ARB_CLEAR_EN
  localparam logic BUSY_RST = 1'b1;
`else
  localparam logic BUSY_RST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_we, m1_req, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_ena, ram_wena;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic          busy;

  ram_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  // Behavioural single-port RAM with registered read data.
  logic [DW-1:0] ram_mem [32];
  logic [DW-1:0] ram_q;
  bit            ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= pat(i);
      ram_init <= 1'b1;
    end else if (ram_ena) begin
      if (ram_wena) ram_mem[ram_addr] <= ram_din;
      else          ram_q <= ram_mem[ram_addr];
    end
  end
  assign ram_dout = ram_q;

  int errors = 0;
  int checks = 0;
  logic [31:0] mem_ref [32];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return 128'({m0_ack, m1_ack, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
                 ram_ena, ram_wena, ram_addr, ram_din});
  endfunction

  typedef struct {
    logic        r0, r1, we0, we1;
    logic [4:0]  a0, a1;
    logic [31:0] d0, d1;
    int          first;
    logic [31:0] rd0, rd1;
  } vec_t;

  function automatic vec_t mkv(input logic r0, input logic r1, input logic we0, input logic we1,
                               input logic [4:0] a0, input logic [4:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1, input int first,
                               input logic [31:0] rd0, input logic [31:0] rd1);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.we0 = we0; v.we1 = we1; v.a0 = a0; v.a1 = a1;
    v.d0 = d0; v.d1 = d1; v.first = first; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  // Presents one record at the start of an IDLE cycle (called #1 after a
  // rising edge), lets each master drop req after its ack, and checks grant
  // order, latencies and read data. Returns at #1 after an edge with the
  // arbiter idle.
  task automatic run_vec(input vec_t v, input string tag);
    int          ack_k[2];
    int          rv_k[2];
    logic [31:0] rd[2];
    logic        rq[2], we[2];
    logic [4:0]  a[2];
    logic [31:0] d[2], erd[2];
    int          first_m, w, o, sec;
    bit          done;
    ack_k = '{-1, -1}; rv_k = '{-1, -1}; rd = '{32'd0, 32'd0}; first_m = -1;
    rq = '{v.r0, v.r1}; we = '{v.we0, v.we1}; a = '{v.a0, v.a1};
    d = '{v.d0, v.d1}; erd = '{v.rd0, v.rd1};
    m0_req = v.r0; m0_we = v.we0; m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.we1; m1_addr = v.a1; m1_wdata = v.d1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (m0_ack && ack_k[0] < 0) begin ack_k[0] = k; if (first_m < 0) first_m = 0; end
      if (m1_ack && ack_k[1] < 0) begin ack_k[1] = k; if (first_m < 0) first_m = 1; end
      if (m0_rvalid && rv_k[0] < 0) begin rv_k[0] = k; rd[0] = m0_rdata; end
      if (m1_rvalid && rv_k[1] < 0) begin rv_k[1] = k; rd[1] = m1_rdata; end
      @(posedge clk); #1;
      if (ack_k[0] >= 0) m0_req = 1'b0;
      if (ack_k[1] >= 0) m1_req = 1'b0;
      done = 1'b1;
      for (int m = 0; m < 2; m++)
        if (rq[m] && (ack_k[m] < 0 || (!we[m] && rv_k[m] < 0))) done = 1'b0;
      if (done) break;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    w = v.first; o = 1 - w;
    check_int({tag, "_winner"}, first_m, w);
    check_int({tag, "_ack_lat"}, ack_k[w], 1);
    if (!we[w]) begin
      check_int({tag, "_rvalid_lat"}, rv_k[w], 3);
      check({tag, "_rdata_first"}, 128'(rd[w]), 128'(erd[w]));
    end
    if (rq[o]) begin
      sec = we[w] ? 3 : 4;
      check_int({tag, "_ack2_lat"}, ack_k[o], sec);
      if (!we[o]) begin
        check_int({tag, "_rvalid2_lat"}, rv_k[o], sec + 2);
        check({tag, "_rdata_second"}, 128'(rd[o]), 128'(erd[o]));
      end
    end else begin
      check_int({tag, "_no_stray_ack"}, ack_k[o], -1);
    end
    if (rq[w] && we[w]) mem_ref[a[w]] = d[w];
    if (rq[o] && we[o]) mem_ref[a[o]] = d[o];
  endtask

  // Randomized-phase state
  bit          pend[2], got_ack[2];
  logic        we_r[2];
  logic [4:0]  addr_r[2];
  logic [31:0] data_r[2];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[11];
    int   k, acks, last_k, g, cyc, next_free, ack_cyc, ack_who, rv_cyc, rv_who, last_m, w;
    bit   s0, s1, saw, rv_seen, ack_rd;
    logic [31:0] rv_data;
    logic e0, e1, r0e, r1e;

    vt[0]  = mkv(1, 0, 1, 0, 5,  0, 32'hDEADBEEF, 0,            0, 0, 0);
    vt[1]  = mkv(1, 0, 0, 0, 5,  0, 0,            0,            0, 32'hDEADBEEF, 0);
    vt[2]  = mkv(1, 1, 1, 1, 2,  1, 32'h22222222, 32'h11111111, 1, 0, 0);
    vt[3]  = mkv(0, 1, 0, 1, 0,  3, 0,            32'h00000033, 1, 0, 0);
    vt[4]  = mkv(1, 1, 0, 0, 1,  2, 0,            0,            0, 32'h11111111, 32'h22222222);
    vt[5]  = mkv(1, 0, 0, 0, 3,  0, 0,            0,            0, 32'h00000033, 0);
    vt[6]  = mkv(0, 1, 0, 0, 0,  5, 0,            0,            1, 0, 32'hDEADBEEF);
    vt[7]  = mkv(1, 1, 1, 1, 7,  7, 32'h0000AAAA, 32'h0000BBBB, 0, 0, 0);
    vt[8]  = mkv(1, 0, 0, 0, 7,  0, 0,            0,            0, 32'h0000BBBB, 0);
    vt[9]  = mkv(1, 1, 1, 1, 31, 0, 32'hFFFFFFFF, 32'h00000001, 1, 0, 0);
    vt[10] = mkv(1, 1, 0, 0, 31, 0, 0,            0,            1, 32'hFFFFFFFF, 32'h00000001);

    for (int i = 0; i < 32; i++) mem_ref[i] = BUSY_RST ? 32'd0 : pat(i);
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    rst_n = 1'b0;
`ifdef RAM_ARB_CLEAR_EN
    m0_req = 1'b1; m0_addr = 5'd31;
`endif
    repeat (3) @(negedge clk);
    check("reset_outs", outs(), '0);
    check("reset_busy", 128'(busy), 128'(BUSY_RST));
    rst_n = 1'b1;

`ifdef RAM_ARB_CLEAR_EN
    k = 0;
    saw = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (m0_ack) begin k = i; saw = 1'b1; break; end
    end
    check("clear_holdoff", 128'(saw && k > 32), 128'(1));
    @(posedge clk); #1; m0_req = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m0_rvalid) begin saw = 1'b1; break; end
    end
    check("clear_rvalid_seen", 128'(saw), 128'(1));
    check("clear_rdata", 128'(m0_rdata), '0);
    @(posedge clk); #1;
    run_vec(mkv(0, 1, 0, 0, 0, 31, 0, 0, 1, 0, 0), "clear_m1");
`else
    @(negedge clk);
    check("post_reset_busy", 128'(busy), '0);
    @(posedge clk); #1;
`endif

    // Table-driven transactions
    for (int i = 0; i < 11; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Continuous dual requests: strict alternation, starting with m1 because
    // the last table grant went to m0.
    m0_req = 1; m0_we = 1; m0_addr = 5'd8;  m0_wdata = 32'hA000_0008;
    m1_req = 1; m1_we = 1; m1_addr = 5'd16; m1_wdata = 32'hB000_0010;
    g = 0; last_k = 0;
    for (k = 0; k < 60 && g < 9; k++) begin
      @(negedge clk);
      s0 = m0_ack; s1 = m1_ack;
      if (s0 || s1) begin
        check($sformatf("alt_grant%0d", g), 128'({s0, s1}), (g % 2 == 0) ? 128'(2'b01) : 128'(2'b10));
        if (g > 0) check_int("alt_spacing", k - last_k, 2);
        last_k = k; g++;
      end
      @(posedge clk); #1;
      if (s0) begin
        mem_ref[m0_addr] = m0_wdata;
        if (g < 8) begin m0_addr = m0_addr + 5'd1; m0_wdata = m0_wdata + 1; end
        else m0_req = 1'b0;
      end
      if (s1) begin
        mem_ref[m1_addr] = m1_wdata;
        if (g < 8) begin m1_addr = m1_addr + 5'd1; m1_wdata = m1_wdata + 1; end
        else m1_req = 1'b0;
      end
    end
    check_int("alt_grant_count", g, 9);
    m0_req = 0; m1_req = 0;

    // m1 back-to-back writes 0..3, then read back.
    m1_req = 1; m1_we = 1; m1_addr = 5'd0; m1_wdata = 32'h10;
    acks = 0; last_k = 0;
    for (k = 0; k < 30 && acks < 4; k++) begin
      @(negedge clk);
      saw = m1_ack;
      if (saw) begin
        if (acks == 0) check_int("stream_first_lat", k, 1);
        else           check_int("stream_spacing", k - last_k, 2);
        last_k = k; acks++;
      end
      @(posedge clk); #1;
      if (saw) begin
        mem_ref[m1_addr] = m1_wdata;
        if (acks < 4) begin m1_addr = m1_addr + 5'd1; m1_wdata = m1_wdata + 1; end
        else m1_req = 1'b0;
      end
    end
    check_int("stream_count", acks, 4);
    m1_req = 0;
    for (int i = 0; i < 4; i++)
      run_vec(mkv(0, 1, 0, 0, 0, 5'(i), 0, 0, 1, 0, 32'h10 + 32'(i)), $sformatf("stream_rd%0d", i));

    // Asynchronous reset during RDATA drops the read.
    m0_req = 1; m0_we = 0; m0_addr = 5'd5;
    @(negedge clk);
    @(posedge clk); #1;
    check("rst_seq_ack", 128'(m0_ack), 128'(1));
    m0_req = 0;
    @(posedge clk); #1;
    check("rst_seq_in_rdata", 128'({busy, m0_ack, m0_rvalid}), 128'(3'b100));
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_outs", outs(), '0);
    check("rst_async_busy", 128'(busy), 128'(BUSY_RST));
    rv_seen = 1'b0;
    repeat (3) begin @(negedge clk); if (m0_rvalid || m1_rvalid) rv_seen = 1'b1; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (m0_rvalid || m1_rvalid) rv_seen = 1'b1; end
    check("rst_no_rvalid", 128'(rv_seen), '0);
`ifdef RAM_ARB_CLEAR_EN
    for (int i = 0; i < 32; i++) mem_ref[i] = 32'd0;
    saw = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin saw = 1'b1; break; end
    end
    check("rst_clear_done", 128'(saw), 128'(1));
`else
    check("rst_release_idle", 128'({busy, m0_rdata}), '0);
`endif

    // Randomized traffic against the cycle-count reference model.
    pend = '{0, 0}; got_ack = '{0, 0};
    we_r = '{0, 0}; addr_r = '{5'd0, 5'd0}; data_r = '{32'd0, 32'd0};
    cyc = 0; next_free = 0; ack_cyc = -100; ack_who = 0; ack_rd = 0;
    rv_cyc = -100; rv_who = 0; rv_data = '0; last_m = 1;
    for (int it = 0; it < 1500; it++) begin
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        if (got_ack[m]) pend[m] = 1'b0;
        if (!pend[m] && $urandom_range(0, 2) != 0) begin
          pend[m]   = 1'b1;
          we_r[m]   = 1'($urandom_range(0, 1));
          addr_r[m] = 5'($urandom_range(0, 31));
          data_r[m] = $urandom;
        end
      end
      m0_req = pend[0]; m0_we = we_r[0]; m0_addr = addr_r[0]; m0_wdata = data_r[0];
      m1_req = pend[1]; m1_we = we_r[1]; m1_addr = addr_r[1]; m1_wdata = data_r[1];
      @(negedge clk);
      e0  = (ack_cyc == cyc) && (ack_who == 0);
      e1  = (ack_cyc == cyc) && (ack_who == 1);
      r0e = (rv_cyc == cyc) && (rv_who == 0);
      r1e = (rv_cyc == cyc) && (rv_who == 1);
      check("rnd_ack", 128'({m0_ack, m1_ack}), 128'({e0, e1}));
      check("rnd_rvalid", 128'({m0_rvalid, m1_rvalid}), 128'({r0e, r1e}));
      check("rnd_busy", 128'(busy), 128'(cyc < next_free));
      check("rnd_ram_cmd", 128'({ram_ena, ram_wena}),
            128'({(cyc == ack_cyc) || (ack_rd && cyc == ack_cyc + 1), (cyc == ack_cyc) && !ack_rd}));
      if (r0e) check("rnd_rdata0", 128'(m0_rdata), 128'(rv_data));
      if (r1e) check("rnd_rdata1", 128'(m1_rdata), 128'(rv_data));
      got_ack[0] = m0_ack; got_ack[1] = m1_ack;
      if (cyc >= next_free && (pend[0] || pend[1])) begin
        w = (pend[0] && pend[1]) ? 1 - last_m : (pend[1] ? 1 : 0);
        last_m = w; ack_cyc = cyc + 1; ack_who = w; ack_rd = !we_r[w];
        if (we_r[w]) begin
          mem_ref[addr_r[w]] = data_r[w];
          next_free = cyc + 2;
        end else begin
          rv_cyc = cyc + 3; rv_who = w; rv_data = mem_ref[addr_r[w]];
          next_free = cyc + 3;
        end
      end
      cyc++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
